// File: rtl/instr_mem_boot.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_boot
//  Description : Boot-loadable instruction memory for the fetch stage. A host
//                streams the program in while in BOOT; in RUN the block serves
//                1-cycle-latency fetches with stall hold, reload and a
//                NOP/fault response for unloaded or out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_boot #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  // boot load interface
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              reload,
  output logic              boot_busy,
  output logic [ADDR_W:0]   load_count,
  // fetch interface
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault
);

  // Index width of the storage array; never wider than ADDR_W because
  // DEPTH is bounded by 2**ADDR_W.
  localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Word count at which loading stops, held at the same width as load_count
  // so a fully populated 2**ADDR_W memory compares correctly.
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  // Reject impossible geometries at elaboration time.
  if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_depth_check
    $error("instr_mem_boot: DEPTH must be in 1 .. 2**ADDR_W");
  end

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_fault;
  logic                w_fault_nxt;
  logic                w_wr_en;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic                w_hit;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // The load count doubles as the write pointer; it never passes DEPTH
  // because the block leaves BOOT on the write that reaches DEPTH.
  assign w_wr_idx = r_count[c_IDX_W-1:0];
  assign w_rd_idx = fetch_addr[c_IDX_W-1:0];
  // Only loaded words are readable; anything at or above load_count
  // (including addresses beyond DEPTH) is a fault. The read index is only
  // used when w_hit is set, so it is always within the array.
  assign w_hit    = ({1'b0, fetch_addr} < r_count);

  // State and fetch-output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
      r_count <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state, load-pointer and fetch-result logic.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_wr_en     = 1'b0;

    case (r_state)
      ST_BOOT: begin
        // Fetches are ignored while booting.
        w_valid_nxt = 1'b0;
        w_fault_nxt = 1'b0;
        if (load_valid) begin
          w_wr_en     = 1'b1;
          w_count_nxt = r_count + 1'b1;
        end
        // A word presented with load_done is still written and counted.
        if (load_done || (load_valid && ((r_count + 1'b1) == c_DEPTH))) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // Stall freezes the fetch outputs, even against reload.
        if (!fetch_stall) begin
          if (reload) begin
            // A fetch presented alongside reload is dropped.
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b0;
          end else if (fetch_req) begin
            w_valid_nxt = 1'b1;
            if (w_hit) begin
              w_instr_nxt = r_mem[w_rd_idx];
              w_fault_nxt = 1'b0;
            end else begin
              w_instr_nxt = NOP_WORD;
              w_fault_nxt = 1'b1;
            end
          end else begin
            // Idle cycle: instr keeps its last value.
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b0;
          end
        end
        if (reload) begin
          w_state_nxt = ST_BOOT;
          w_count_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
        w_count_nxt = '0;
      end
    endcase
  end

  // Program storage; deliberately not reset, stale words stay unreadable.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= load_data;
    end
  end

  assign load_ready  = (r_state == ST_BOOT);
  assign boot_busy   = (r_state == ST_BOOT);
  assign load_count  = r_count;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign addr_fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_boot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_boot
//  Description : Self-checking bench for instr_mem_boot. Two instances
//                (DEPTH=32 and DEPTH=30) share one stimulus stream and are
//                compared every cycle against a behavioural program model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_boot;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic          reload;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;

  logic          ready [2];
  logic          busy  [2];
  logic [AW:0]   cnt   [2];
  logic [DW-1:0] ins   [2];
  logic          vld   [2];
  logic          flt   [2];

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model state, one slot per instance
  logic [DW-1:0] m_mem   [2][32];
  int            m_cnt   [2];
  bit            m_boot  [2];
  logic [DW-1:0] m_instr [2];
  bit            m_valid [2];
  bit            m_fault [2];
  int            m_depth [2] = '{32, 30};
  logic [DW-1:0] m_nop   [2] = '{32'h0000_0000, 32'h0000_0013};

  instr_mem_boot #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(32), .NOP_WORD(32'h0000_0000)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(ready[0]),
    .load_done(load_done), .reload(reload), .boot_busy(busy[0]), .load_count(cnt[0]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .instr(ins[0]), .instr_valid(vld[0]), .addr_fault(flt[0])
  );

  instr_mem_boot #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(30), .NOP_WORD(32'h0000_0013)) u_dut30 (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(ready[1]),
    .load_done(load_done), .reload(reload), .boot_busy(busy[1]), .load_count(cnt[1]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .instr(ins[1]), .instr_valid(vld[1]), .addr_fault(flt[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_boot[i]  = 1'b1;
      m_instr[i] = '0;
      m_valid[i] = 1'b0;
      m_fault[i] = 1'b0;
    end
  endtask

  // One clock edge of the program-memory behaviour, applied to the inputs
  // that were stable across that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_boot[i]) begin
        m_valid[i] = 1'b0;
        m_fault[i] = 1'b0;
        if (load_valid) begin
          m_mem[i][m_cnt[i]] = load_data;
          m_cnt[i]++;
        end
        if (load_done || m_cnt[i] == m_depth[i]) m_boot[i] = 1'b0;
      end else begin
        if (!fetch_stall) begin
          if (reload || !fetch_req) begin
            m_valid[i] = 1'b0;
            m_fault[i] = 1'b0;
          end else begin
            m_valid[i] = 1'b1;
            if (int'(fetch_addr) < m_cnt[i]) begin
              m_instr[i] = m_mem[i][fetch_addr];
              m_fault[i] = 1'b0;
            end else begin
              m_instr[i] = m_nop[i];
              m_fault[i] = 1'b1;
            end
          end
        end
        if (reload) begin
          m_boot[i] = 1'b1;
          m_cnt[i]  = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_ready", i), ready[i], m_boot[i]);
      chk($sformatf("d%0d_busy", i),  busy[i],  m_boot[i]);
      chk($sformatf("d%0d_count", i), cnt[i],   m_cnt[i]);
      chk($sformatf("d%0d_instr", i), ins[i],   m_instr[i]);
      chk($sformatf("d%0d_valid", i), vld[i],   m_valid[i]);
      chk($sformatf("d%0d_fault", i), flt[i],   m_fault[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    load_valid  = 1'b0;
    load_data   = '0;
    load_done   = 1'b0;
    reload      = 1'b0;
    fetch_req   = 1'b0;
    fetch_addr  = '0;
    fetch_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic load_word(input logic [31:0] d, input bit done);
    idle_inputs();
    load_valid = 1'b1;
    load_data  = d;
    load_done  = done;
    step();
    idle_inputs();
  endtask

  task automatic fetch(input int a, input bit stall);
    idle_inputs();
    fetch_req   = 1'b1;
    fetch_addr  = AW'(a);
    fetch_stall = stall;
    step();
    idle_inputs();
  endtask

  logic [31:0] prog [4] = '{32'h3408_4D4C, 32'h0008_4825, 32'h1109_0002, 32'h240F_0001};

  initial begin
    idle_inputs();
    reset_n = 1'b1;
    #2;
    do_reset();

    // Load four words, load_done with the last one, then fetch address 2.
    for (int k = 0; k < 4; k++) load_word(prog[k], k == 3);
    chk("s1_count", cnt[0], 32'd4);
    chk("s1_busy", busy[0], 1'b0);
    fetch(2, 1'b0);
    chk("s1_instr", ins[0], 32'h1109_0002);
    chk("s1_valid", vld[0], 1'b1);

    // Unloaded and beyond-loaded addresses fault with the NOP word.
    fetch(5, 1'b0);
    chk("s2_fault5", flt[0], 1'b1);
    fetch(31, 1'b0);
    chk("s2_instr31", ins[0], 32'h0);

    // Back-to-back fetches, then a stall holding the second result.
    fetch(0, 1'b0);
    fetch(1, 1'b0);
    fetch(3, 1'b1);
    fetch(3, 1'b1);
    chk("s3_hold", ins[0], 32'h0008_4825);
    fetch(3, 1'b0);
    chk("s3_addr3", ins[0], 32'h240F_0001);

    // Reload with a concurrent fetch drops the fetch and re-enters BOOT.
    idle_inputs();
    reload = 1'b1; fetch_req = 1'b1;
    step();
    idle_inputs();
    chk("s5_valid", vld[0], 1'b0);
    chk("s5_ready", ready[0], 1'b1);
    // Fetch during BOOT is ignored.
    fetch(0, 1'b0);
    chk("s4_boot_valid", vld[0], 1'b0);
    load_word(32'h2415_0015, 1'b1);
    fetch(0, 1'b0);
    chk("s5_instr", ins[0], 32'h2415_0015);

    // load_done with no words: every fetch faults.
    do_reset();
    idle_inputs(); load_done = 1'b1; step(); idle_inputs();
    fetch(0, 1'b0);
    chk("s4_empty_fault", flt[0], 1'b1);

    // Fill: the DEPTH=30 copy stops at 30, the 32-word copy at 32.
    do_reset();
    for (int k = 0; k < 30; k++) load_word($urandom, 1'b0);
    chk("s2_ready30", ready[1], 1'b0);
    fetch(30, 1'b0);
    chk("s2_fault30", flt[1], 1'b1);
    load_word($urandom, 1'b0);
    load_word($urandom, 1'b0);
    chk("s2_count32", cnt[0], 32'd32);
    fetch(31, 1'b0);
    chk("s2_hit31", flt[0], 1'b0);

    // Asynchronous reset mid-load after two words.
    do_reset();
    load_word(32'h1111_1111, 1'b0);
    idle_inputs(); load_valid = 1'b1; load_data = 32'h2222_2222;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("s6_async_count", cnt[0], 32'd0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    load_done = 1'b1; step(); idle_inputs();
    fetch(0, 1'b0);
    chk("s6_fault", flt[0], 1'b1);

    // Randomised traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      load_valid  = ($urandom_range(0, 2) != 0);
      load_data   = $urandom;
      load_done   = ($urandom_range(0, 11) == 0);
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_addr  = AW'($urandom_range(0, 31));
      fetch_stall = ($urandom_range(0, 4) == 0);
      reload      = ($urandom_range(0, 39) == 0);
      step();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
